// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the IF/ID slot and redirect.
// master = fetch unit, slave = memory / decode side.
interface instr_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_rvalid;
    logic [31:0]       if_instr;
    logic [ADDR_W-1:0] if_pc_plus4;
    logic              if_valid;
    logic              id_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;

    modport master (
        output imem_req, imem_addr, if_instr, if_pc_plus4, if_valid,
        input  imem_rdata, imem_rvalid, id_ready, redirect_valid, redirect_target
    );

    modport slave (
        input  imem_req, imem_addr, if_instr, if_pc_plus4, if_valid,
        output imem_rdata, imem_rvalid, id_ready, redirect_valid, redirect_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding imem handshake and
// holds a one-entry IF/ID slot that is flushed to a bubble on branch/jump redirect.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [31:0]       NOP_WORD = 32'hFC00_0000
) (
    input logic           clk,
    input logic           rst_n,
    instr_fetch_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        WAIT_ID = 2'd2,
        DROP    = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] redirect_pc;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] pc_plus4_q;
    logic              valid_q;
    logic              req_q;
    logic              unused_target_lsbs;

    assign pc_inc             = pc + ADDR_W'(4);
    assign redirect_pc        = {bus.redirect_target[ADDR_W-1:2], 2'b00};
    assign unused_target_lsbs = ^bus.redirect_target[1:0];

    // NOTE: all state is assigned non-blocking so every register sees pre-edge values,
    // and the async reset branch clears the request before any clock edge arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            instr_q    <= NOP_WORD;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
        end else if (bus.redirect_valid) begin
            // Redirect beats every other event; a still-outstanding response must be
            // drained in DROP so it can never be mistaken for the new target's word.
            pc      <= redirect_pc;
            valid_q <= 1'b0;
            instr_q <= NOP_WORD;
            if ((state == FETCH || state == DROP) && !bus.imem_rvalid) begin
                state <= DROP;
                req_q <= 1'b0;
            end else begin
                state <= FETCH;
                req_q <= 1'b1;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                end
                FETCH: begin
                    if (bus.imem_rvalid) begin
                        instr_q    <= bus.imem_rdata;
                        pc_plus4_q <= pc_inc;
                        valid_q    <= 1'b1;
                        pc         <= pc_inc;
                        state      <= WAIT_ID;
                        req_q      <= 1'b0;
                    end
                end
                WAIT_ID: begin
                    if (bus.id_ready) begin
                        valid_q <= 1'b0;
                        instr_q <= NOP_WORD;
                        state   <= FETCH;
                        req_q   <= 1'b1;
                    end
                end
                DROP: begin
                    if (bus.imem_rvalid) begin
                        state <= FETCH;
                        req_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc;
    assign bus.if_instr    = instr_q;
    assign bus.if_pc_plus4 = pc_plus4_q;
    assign bus.if_valid    = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed boot/backpressure/redirect/wrap/reset
// scenarios followed by randomized traffic, all checked against a transaction-level model.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'hFC00_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_W(32)) bus ();

    instr_fetch_unit #(
        .ADDR_W  (32),
        .RESET_PC(32'h0000_0000),
        .NOP_WORD(NOP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: exp_pc is the address of the next instruction in program order.
    logic [31:0] exp_pc     = 32'h0;
    logic [31:0] salt       = 32'h1;
    bit          last_valid = 1'b0;
    logic [31:0] last_instr = NOP;
    bit          prev_redir = 1'b0;
    bit          prev_rdy   = 1'b0;
    logic [31:0] prev_tgt   = 32'h0;
    int          since_valid = 0;

    // Instruction memory with variable latency
    bit          pending   = 1'b0;
    int          cnt       = 0;
    logic [31:0] maddr     = 32'h0;

    // Stimulus controls
    int          rdy_mode  = 2;   // 0 random, 1 always ready, 2 never ready
    int          redir_pct = 0;
    int          mem_delay = 1;   // <0 picks a random latency per request
    bit          redir_shot = 1'b0;
    logic [31:0] redir_shot_tgt = 32'h0;
    bit          stray_rvalid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        if (a[5:2] == 4'd7) return NOP;
        return {a[15:0], a[31:16]} ^ salt;
    endfunction

    function automatic logic [31:0] rand_target();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            2:       return 32'($urandom_range(0, 255));
            default: return 32'h0000_1000 + 32'($urandom_range(0, 63));
        endcase
    endfunction

    // One clock: sample at the falling edge, update model, run memory, drive next inputs.
    task automatic cycle();
        @(negedge clk);
        if (prev_redir) exp_pc = prev_tgt & 32'hFFFF_FFFC;
        else if (last_valid && prev_rdy) exp_pc = exp_pc + 32'd4;

        if (prev_redir) begin
            check("flush_valid", 32'(bus.if_valid), 32'd0);
        end else if (last_valid && prev_rdy) begin
            check("no_reissue", 32'(bus.if_valid), 32'd0);
        end else if (last_valid) begin
            check("hold_valid", 32'(bus.if_valid), 32'd1);
            check("hold_instr", bus.if_instr, last_instr);
        end

        if (bus.if_valid) begin
            check("slot_instr", bus.if_instr, mem_word(exp_pc));
            check("slot_pc4", bus.if_pc_plus4, exp_pc + 32'd4);
            check("slot_req_low", 32'(bus.imem_req), 32'd0);
            since_valid = 0;
        end else begin
            check("bubble_instr", bus.if_instr, NOP);
            since_valid++;
        end
        if (bus.imem_req) check("fetch_addr", bus.imem_addr, exp_pc);
        if (since_valid > 100) begin
            check("progress_timeout", 32'(bus.if_valid), 32'd1);
            since_valid = 0;
        end
        last_valid = bus.if_valid;
        last_instr = bus.if_instr;

        if (bus.imem_rvalid) pending = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
        if (bus.imem_req && !pending) begin
            pending = 1'b1;
            maddr   = bus.imem_addr;
            cnt     = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
        end
        if (pending) begin
            if (cnt == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(maddr);
            end else begin
                cnt--;
            end
        end
        if (stray_rvalid) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hDEAD_BEEF;
            stray_rvalid    = 1'b0;
        end

        case (rdy_mode)
            1:       bus.id_ready = 1'b1;
            2:       bus.id_ready = 1'b0;
            default: bus.id_ready = ($urandom_range(0, 9) < 7);
        endcase
        if (redir_shot) begin
            bus.redirect_valid  = 1'b1;
            bus.redirect_target = redir_shot_tgt;
            redir_shot          = 1'b0;
        end else if (int'($urandom_range(0, 99)) < redir_pct) begin
            bus.redirect_valid  = 1'b1;
            bus.redirect_target = rand_target();
        end else begin
            bus.redirect_valid  = 1'b0;
            bus.redirect_target = $urandom;
        end
        prev_redir = bus.redirect_valid;
        prev_tgt   = bus.redirect_target;
        prev_rdy   = bus.id_ready;
    endtask

    // Hold reset for n cycles, then release with a late rvalid landing in IDLE.
    task automatic do_reset(input int n);
        rst_n               = 1'b0;
        bus.imem_rvalid     = 1'b0;
        bus.imem_rdata      = 32'h0;
        bus.id_ready        = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        repeat (n) @(negedge clk);
        rst_n           = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hBAD0_BAD0;
        exp_pc      = 32'h0;
        last_valid  = 1'b0;
        last_instr  = NOP;
        prev_redir  = 1'b0;
        prev_rdy    = 1'b0;
        pending     = 1'b0;
        since_valid = 0;
    endtask

    task automatic async_reset_check(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_req"}, 32'(bus.imem_req), 32'd0);
        check({tag, "_valid"}, 32'(bus.if_valid), 32'd0);
        check({tag, "_instr"}, bus.if_instr, NOP);
        check({tag, "_pc4"}, bus.if_pc_plus4, 32'd0);
    endtask

    initial begin
        salt = $urandom | 32'h1;

        // Boot
        mem_delay = 1;
        rdy_mode  = 2;
        do_reset(3);
        cycle();
        check("boot_req", 32'(bus.imem_req), 32'd1);
        check("boot_addr", bus.imem_addr, 32'h0);
        cycle();
        cycle();
        check("boot_valid", 32'(bus.if_valid), 32'd1);
        check("boot_instr", bus.if_instr, 32'h2008_0005);
        check("boot_pc4", bus.if_pc_plus4, 32'd4);

        // Backpressure
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_valid", 32'(bus.if_valid), 32'd1);
            check("bp_req", 32'(bus.imem_req), 32'd0);
            check("bp_instr", bus.if_instr, 32'h2008_0005);
        end
        mem_delay = 3;
        rdy_mode  = 1;
        cycle();
        cycle();
        check("bp_next_req", 32'(bus.imem_req), 32'd1);
        check("bp_next_addr", bus.imem_addr, 32'h4);

        // Redirect while a 3-cycle fetch is outstanding
        redir_shot     = 1'b1;
        redir_shot_tgt = 32'h40;
        cycle();
        cycle();
        check("drop_req", 32'(bus.imem_req), 32'd0);
        check("drop_valid", 32'(bus.if_valid), 32'd0);
        for (int i = 0; i < 10 && !bus.imem_req; i++) cycle();
        check("redir_req", 32'(bus.imem_req), 32'd1);
        check("redir_addr", bus.imem_addr, 32'h40);

        // Redirect + rvalid + id_ready together in WAIT_ID
        mem_delay = 1;
        rdy_mode  = 2;
        for (int i = 0; i < 20 && !bus.if_valid; i++) cycle();
        check("t4_slot_full", 32'(bus.if_valid), 32'd1);
        redir_shot     = 1'b1;
        redir_shot_tgt = 32'h103;
        stray_rvalid   = 1'b1;
        rdy_mode       = 1;
        cycle();
        cycle();
        check("t4_valid", 32'(bus.if_valid), 32'd0);
        check("t4_instr", bus.if_instr, NOP);
        check("t4_req", 32'(bus.imem_req), 32'd1);
        check("t4_addr", bus.imem_addr, 32'h100);

        // PC wrap
        redir_shot     = 1'b1;
        redir_shot_tgt = 32'hFFFF_FFFC;
        cycle();
        for (int i = 0; i < 20 && !bus.if_valid; i++) cycle();
        check("wrap_valid", 32'(bus.if_valid), 32'd1);
        check("wrap_pc4", bus.if_pc_plus4, 32'h0);
        mem_delay = 3;
        cycle();
        check("wrap_req", 32'(bus.imem_req), 32'd1);
        check("wrap_addr", bus.imem_addr, 32'h0);

        // Async reset mid-fetch from a non-reset address
        redir_shot     = 1'b1;
        redir_shot_tgt = 32'h200;
        cycle();
        for (int i = 0; i < 10 && !bus.imem_req; i++) cycle();
        check("pre_rst_req", 32'(bus.imem_req), 32'd1);
        async_reset_check("rst");
        do_reset(2);
        cycle();
        check("rst_restart_req", 32'(bus.imem_req), 32'd1);
        check("rst_restart_addr", bus.imem_addr, 32'h0);

        // Randomized traffic, with an async reset in the middle
        rdy_mode  = 0;
        redir_pct = 8;
        mem_delay = -1;
        repeat (1500) cycle();
        async_reset_check("rand_rst");
        do_reset(2);
        repeat (1500) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
